// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: display back-end for the calculator.
// Captures a signed result, converts it to BCD with shift-add-3 and scans four
// common-anode 7-segment digits (active-low anodes and segments).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned ANODE_WIDTH   = 4,
  parameter int unsigned SEGMENT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    value,
  input  logic                     value_valid,
  input  logic                     err,
  input  logic                     point,
  output logic                     busy,
  output logic [ANODE_WIDTH-1:0]   anodes,
  output logic [SEGMENT_WIDTH-1:0] segments
);

  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned STEP_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned BCD_W  = 16;

  localparam logic [SEGMENT_WIDTH-1:0] SEG_ZERO  = SEGMENT_WIDTH'(8'hC0);
  localparam logic [SEGMENT_WIDTH-1:0] SEG_E     = SEGMENT_WIDTH'(8'h86);
  localparam logic [SEGMENT_WIDTH-1:0] SEG_MINUS = SEGMENT_WIDTH'(8'hBF);
  localparam logic [SEGMENT_WIDTH-1:0] SEG_BLANK = SEGMENT_WIDTH'(8'hFF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [STEP_W-1:0]       r_step;
  logic                    r_cap_err;
  logic                    r_cap_neg;
  logic                    r_cap_point;
  logic [BCD_W-1:0]        r_disp_bcd;
  logic                    r_disp_err;
  logic                    r_disp_neg;
  logic                    r_disp_point;

  logic [CNT_W-1:0]         r_div_cnt;
  logic [1:0]               r_idx;
  logic [ANODE_WIDTH-1:0]   r_anodes;
  logic [SEGMENT_WIDTH-1:0] r_segments;

  logic                     w_neg;
  logic                     w_min;
  logic [DATA_WIDTH-1:0]    w_mag;
  logic                     w_ovf;
  logic [BCD_W-1:0]         w_bcd_adj;
  logic                     w_wrap;
  logic [1:0]               w_idx_next;
  logic [3:0]               w_nib;
  logic [SEGMENT_WIDTH-1:0] w_seg_next;

  function automatic logic [SEGMENT_WIDTH-1:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = SEGMENT_WIDTH'(8'hC0);
      4'd1:    seg_of = SEGMENT_WIDTH'(8'hF9);
      4'd2:    seg_of = SEGMENT_WIDTH'(8'hA4);
      4'd3:    seg_of = SEGMENT_WIDTH'(8'hB0);
      4'd4:    seg_of = SEGMENT_WIDTH'(8'h99);
      4'd5:    seg_of = SEGMENT_WIDTH'(8'h92);
      4'd6:    seg_of = SEGMENT_WIDTH'(8'h82);
      4'd7:    seg_of = SEGMENT_WIDTH'(8'hF8);
      4'd8:    seg_of = SEGMENT_WIDTH'(8'h80);
      4'd9:    seg_of = SEGMENT_WIDTH'(8'h90);
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Sign, magnitude and range check of the incoming operand
  always_comb begin
    w_neg = value[DATA_WIDTH-1];
    w_min = w_neg && (value[DATA_WIDTH-2:0] == '0);
    w_mag = w_neg ? DATA_WIDTH'(~value + DATA_WIDTH'(1)) : value;
    w_ovf = w_min
         || (!w_neg && (32'(w_mag) > 32'd9999))
         || ( w_neg && (32'(w_mag) > 32'd999));
  end

  // Add-3 correction of every BCD nibble that is 5 or more before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Capture / convert / commit FSM; a new valid pulse always restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_step       <= '0;
      r_cap_err    <= 1'b0;
      r_cap_neg    <= 1'b0;
      r_cap_point  <= 1'b0;
      r_disp_bcd   <= '0;
      r_disp_err   <= 1'b0;
      r_disp_neg   <= 1'b0;
      r_disp_point <= 1'b0;
    end else if (value_valid) begin
      r_state     <= S_CONV;
      r_busy      <= 1'b1;
      r_bin       <= w_mag;
      r_bcd       <= '0;
      r_step      <= '0;
      r_cap_err   <= err | w_ovf;
      r_cap_neg   <= w_neg;
      r_cap_point <= point;
    end else begin
      case (r_state)
        S_CONV: begin
          r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
          r_bin  <= {r_bin[DATA_WIDTH-2:0], 1'b0};
          r_step <= r_step + STEP_W'(1);
          if (r_step == STEP_W'(DATA_WIDTH - 1)) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_disp_bcd   <= r_bcd;
          r_disp_err   <= r_cap_err;
          r_disp_neg   <= r_cap_neg;
          r_disp_point <= r_cap_point;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Segment pattern for the digit that will be selected after this edge
  always_comb begin
    w_wrap     = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
    w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;
    w_nib      = r_disp_bcd[4*w_idx_next +: 4];
    w_seg_next = seg_of(w_nib);
    if (r_disp_neg && (w_idx_next == 2'd3)) begin
      w_seg_next = SEG_MINUS;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if ((w_idx_next != 2'd0)
        && !(r_disp_point && (w_idx_next <= 2'd2))
        && !(r_disp_neg && (w_idx_next == 2'd3))
        && ((r_disp_bcd >> {w_idx_next, 2'b00}) == '0)) begin
      w_seg_next = SEG_BLANK;
    end
`endif
    if (r_disp_point && (w_idx_next == 2'd2)) begin
      w_seg_next[SEGMENT_WIDTH-1] = 1'b0;
    end
    if (r_disp_err) begin
      w_seg_next = (w_idx_next == 2'd0) ? SEG_E : SEG_ZERO;
    end
  end

  // Free-running refresh divider and digit scan; anodes and segments move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_idx      <= 2'd0;
      r_anodes   <= ANODE_WIDTH'(4'b1110);
      r_segments <= SEG_ZERO;
    end else begin
      r_div_cnt  <= w_wrap ? '0 : (r_div_cnt + CNT_W'(1));
      r_idx      <= w_idx_next;
      r_anodes   <= ~(ANODE_WIDTH'(1) << w_idx_next);
      r_segments <= w_seg_next;
    end
  end

  assign busy     = r_busy;
  assign anodes   = r_anodes;
  assign segments = r_segments;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with an arithmetic display model.
module tb_seg7_scan_driver;

  localparam int unsigned DW = 16;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] value;
  logic          value_valid;
  logic          err;
  logic          point;
  logic          busy;
  logic [3:0]    anodes;
  logic [7:0]    segments;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DATA_WIDTH(DW), .REFRESH_DIV(RD), .ANODE_WIDTH(4), .SEGMENT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
    .err(err), .point(point), .busy(busy), .anodes(anodes), .segments(segments)
  );

  function automatic logic [7:0] enc(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  // Expected pattern of digit position d for a displayed result
  function automatic logic [7:0] ref_seg(input int v, input bit e, input bit p, input int d);
    int p10 [4];
    int mag;
    bit neg;
    logic [7:0] s;
    p10 = '{1, 10, 100, 1000};
    neg = (v < 0);
    mag = neg ? -v : v;
    if (e || (!neg && mag > 9999) || (neg && mag > 999))
      return (d == 0) ? 8'h86 : 8'hC0;
    if (neg && d == 3) s = 8'hBF;
    else               s = enc((mag / p10[d]) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && !(neg && d == 3) && !(p && d <= 2) && mag < p10[d]) s = 8'hFF;
`endif
    if (p && d == 2) s[7] = 1'b0;
    return s;
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input bit e, input bit p);
    @(negedge clk);
    value = DW'(v); err = e; point = p; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  // Counts negedges with busy high; bounded so a stuck FSM still ends the run
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check_int({tag, "_timeout"}, n, DW + 1);
  endtask

  // Samples one full scan rotation and compares every lit digit to the model
  task automatic check_display(input string tag, input int v, input bit e, input bit p);
    int d;
    for (int k = 0; k < 4 * RD + 2; k++) begin
      @(negedge clk);
      d = digit_of(anodes);
      if (d < 0) check8({tag, "_anode"}, {4'h0, anodes}, 8'h0E);
      else       check8($sformatf("%s_d%0d", tag, d), segments, ref_seg(v, e, p, d));
    end
  endtask

  task automatic run_case(input string tag, input int v, input bit e, input bit p);
    int n;
    send(v, e, p);
    wait_idle(tag, n);
    check_display(tag, v, e, p);
  endtask

  initial begin
    int n;
    int v, v0;
    bit e, p;
    int b_list [6];
    b_list = '{9999, 10000, -999, -1000, -32768, 32767};

    rst = 1'b1; value = '0; value_valid = 1'b0; err = 1'b0; point = 1'b0;
    repeat (3) @(negedge clk);
    check8("rst_anodes", {4'h0, anodes}, 8'h0E);
    check8("rst_segments", segments, 8'hC0);
    check_int("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Reset mid-scan, then scan order and per-digit dwell
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check8("midrst_anodes", {4'h0, anodes}, 8'h0E);
    check8("midrst_segments", segments, 8'hC0);
    repeat (2) @(negedge clk);
    check8("inrst_anodes", {4'h0, anodes}, 8'h0E);
    check8("inrst_segments", segments, 8'hC0);
    rst = 1'b0;
    for (int k = 1; k <= 8 * int'(RD); k++) begin
      @(negedge clk);
      check8($sformatf("scan_k%0d", k), {4'h0, anodes},
             {4'h0, ~(4'b0001 << ((k / RD) % 4))});
      check8($sformatf("scan_seg_k%0d", k), segments, ref_seg(0, 1'b0, 1'b0, (k / RD) % 4));
    end

    // Latency and basic value
    send(225, 1'b0, 1'b0);
    wait_idle("v225", n);
    check_int("busy_cycles_225", n, DW + 1);
    check_display("v225", 225, 1'b0, 1'b0);

    run_case("vneg14", -14, 1'b0, 1'b0);
    run_case("v1500p", 1500, 1'b0, 1'b1);
    run_case("err123", 123, 1'b1, 1'b1);
    run_case("ovf10000", 10000, 1'b0, 1'b0);
    run_case("ovfm1000", -1000, 1'b0, 1'b0);
    run_case("v9999", 9999, 1'b0, 1'b0);
    run_case("vm999", -999, 1'b0, 1'b1);
    run_case("vmin", -32768, 1'b0, 1'b0);
    run_case("v0", 0, 1'b0, 1'b0);

    // Abort: last pulse wins and the aborted value never appears
    send(7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    send(9, 1'b0, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      check_int("abort_no7", int'(segments == 8'hF8), 0);
      n++;
      @(negedge clk);
    end
    check_int("abort_busy_cycles", n, DW + 1);
    check_display("abort9", 9, 1'b0, 1'b0);

    // Reset during conversion clears the display and busy
    send(4321, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_int("rstconv_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    check_int("rstconv_busy_after", int'(busy), 0);
    check_display("rstconv", 0, 1'b0, 1'b0);

    // Randomized operands, some with an aborted predecessor
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 10998)) - 999;
        1:       v = int'($signed(16'($urandom)));
        2:       v = b_list[$urandom_range(0, 5)];
        default: v = int'($urandom_range(0, 99));
      endcase
      e = ($urandom_range(0, 7) == 0);
      p = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        v0 = int'($urandom_range(0, 9999));
        send(v0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 15)) @(negedge clk);
      end
      run_case($sformatf("rnd%0d", i), v, e, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
